// File: rtl/hanming_decoder_pkg.sv
// Shared definitions for the 12-bit Hamming codeword: bit positions,
// correctable syndromes and the syndrome function used by encoder and decoder.
package hanming_decoder_pkg;

   localparam int unsigned C1 = 0;
   localparam int unsigned C2 = 1;
   localparam int unsigned D0 = 2;
   localparam int unsigned C3 = 3;
   localparam int unsigned D1 = 4;
   localparam int unsigned D2 = 5;
   localparam int unsigned D3 = 6;
   localparam int unsigned C4 = 7;
   localparam int unsigned D4 = 8;
   localparam int unsigned D5 = 9;
   localparam int unsigned D6 = 10;
   localparam int unsigned D7 = 11;

   localparam logic [3:0] SYN_D2 = 4'b0011;
   localparam logic [3:0] SYN_D4 = 4'b0101;
   localparam logic [3:0] SYN_D5 = 4'b0110;
   localparam logic [3:0] SYN_D6 = 4'b0111;

   function automatic logic [3:0] calc_syndrome(input logic [11:0] cw);
      logic s1, s2, s3, s4;
      s1 = cw[C1] ^ cw[D0] ^ cw[D2] ^ cw[D4] ^ cw[D6];
      s2 = cw[C2] ^ cw[D1] ^ cw[D2] ^ cw[D5] ^ cw[D6];
      s3 = cw[C3] ^ cw[D3] ^ cw[D4] ^ cw[D5] ^ cw[D6];
      s4 = cw[C4] ^ cw[D7];
      return {s4, s3, s2, s1};
   endfunction

   function automatic logic [7:0] data_field(input logic [11:0] cw);
      return {cw[D7], cw[D6], cw[D5], cw[D4], cw[D3], cw[D2], cw[D1], cw[D0]};
   endfunction

endpackage

// File: rtl/hanming_err_counter.sv
// Saturating event counter with synchronous clear; en gates both clear and count.
module hanming_err_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (en) begin
         if (clr)
            count <= '0;
         else if (inc && (count != '1))
            count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/hanming_decoder.sv
// Three-stage Hamming decoder: capture, syndrome, correct/flag, plus
// saturating corrected/uncorrected error counters.
module hanming_decoder
   import hanming_decoder_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             EN,
   input  logic [11:0]      Data_in,
   input  logic             Data_vld,
   input  logic             cnt_clr,
   output logic [7:0]       Data_out,
   output logic             qvld,
   output logic [3:0]       syndrome,
   output logic             err_corr,
   output logic             err_uncorr,
   output logic [CNT_W-1:0] corr_cnt,
   output logic [CNT_W-1:0] uncorr_cnt
);

   logic        v1, v2;
   logic [11:0] cw1, cw2;
   logic [3:0]  syn2;
   logic [7:0]  data_fix;
   logic        corr_hit;
   logic        corr_next;
   logic        uncorr_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         v1   <= 1'b0;
         cw1  <= '0;
         v2   <= 1'b0;
         cw2  <= '0;
         syn2 <= '0;
      end else if (EN) begin
         v1 <= Data_vld;
         if (Data_vld)
            cw1 <= Data_in;
         v2 <= v1;
         if (v1) begin
            cw2  <= cw1;
            syn2 <= calc_syndrome(cw1);
         end
      end
   end

   // Weight-1 syndromes are deliberately not in the correctable set: they
   // cannot distinguish a check-bit error from a d0/d1/d3/d7 error.
   always_comb begin
      data_fix = data_field(cw2);
      corr_hit = 1'b1;
      case (syn2)
         SYN_D2:  data_fix[2] = ~data_fix[2];
         SYN_D4:  data_fix[4] = ~data_fix[4];
         SYN_D5:  data_fix[5] = ~data_fix[5];
         SYN_D6:  data_fix[6] = ~data_fix[6];
         default: corr_hit = 1'b0;
      endcase
      corr_next   = v2 && corr_hit;
      uncorr_next = v2 && !corr_hit && (syn2 != '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         Data_out   <= '0;
         qvld       <= 1'b0;
         syndrome   <= '0;
         err_corr   <= 1'b0;
         err_uncorr <= 1'b0;
      end else if (EN) begin
         qvld       <= v2;
         err_corr   <= corr_next;
         err_uncorr <= uncorr_next;
         if (v2) begin
            Data_out <= data_fix;
            syndrome <= syn2;
         end
      end
   end

   hanming_err_counter #(.CNT_W(CNT_W)) u_corr_cnt (
      .clk   (clk),
      .rst   (rst),
      .en    (EN),
      .clr   (cnt_clr),
      .inc   (corr_next),
      .count (corr_cnt)
   );

   hanming_err_counter #(.CNT_W(CNT_W)) u_uncorr_cnt (
      .clk   (clk),
      .rst   (rst),
      .en    (EN),
      .clr   (cnt_clr),
      .inc   (uncorr_next),
      .count (uncorr_cnt)
   );

endmodule

// File: tb/tb_hanming_decoder.sv
// Directed bench for hanming_decoder with 4-bit counters so saturation is reachable.
module tb_hanming_decoder;

   localparam int unsigned CNT_W = 4;

   logic             clk;
   logic             rst;
   logic             EN;
   logic [11:0]      Data_in;
   logic             Data_vld;
   logic             cnt_clr;
   logic [7:0]       Data_out;
   logic             qvld;
   logic [3:0]       syndrome;
   logic             err_corr;
   logic             err_uncorr;
   logic [CNT_W-1:0] corr_cnt;
   logic [CNT_W-1:0] uncorr_cnt;

   int checks   = 0;
   int failures = 0;

   hanming_decoder #(.CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .EN         (EN),
      .Data_in    (Data_in),
      .Data_vld   (Data_vld),
      .cnt_clr    (cnt_clr),
      .Data_out   (Data_out),
      .qvld       (qvld),
      .syndrome   (syndrome),
      .err_corr   (err_corr),
      .err_uncorr (err_uncorr),
      .corr_cnt   (corr_cnt),
      .uncorr_cnt (uncorr_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp)
      else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // One codeword; returns just after the third edge, when its result is on the outputs.
   task automatic send(input logic [11:0] cw);
      Data_in  = cw;
      Data_vld = 1'b1;
      tick();
      Data_vld = 1'b0;
      tick();
      tick();
   endtask

   task automatic chk_out(input string tag, input logic [7:0] d, input logic [3:0] s,
                          input logic c, input logic u);
      chk({tag, "_qvld"}, {31'd0, qvld}, 32'd1);
      chk({tag, "_data"}, {24'd0, Data_out}, {24'd0, d});
      chk({tag, "_syn"}, {28'd0, syndrome}, {28'd0, s});
      chk({tag, "_corr"}, {31'd0, err_corr}, {31'd0, c});
      chk({tag, "_uncorr"}, {31'd0, err_uncorr}, {31'd0, u});
   endtask

   initial begin
      rst      = 1'b1;
      EN       = 1'b1;
      Data_in  = '0;
      Data_vld = 1'b0;
      cnt_clr  = 1'b0;
      tick();
      tick();
      rst = 1'b0;

      chk("rst_qvld", {31'd0, qvld}, 32'd0);
      chk("rst_data", {24'd0, Data_out}, 32'd0);
      chk("rst_syn", {28'd0, syndrome}, 32'd0);
      chk("rst_flags", {30'd0, err_corr, err_uncorr}, 32'd0);
      chk("rst_cnts", {24'd0, corr_cnt, uncorr_cnt}, 32'd0);

      send(12'hAAC);
      chk_out("clean", 8'hA5, 4'b0000, 1'b0, 1'b0);
      tick();
      chk("clean_pulse", {31'd0, qvld}, 32'd0);
      chk("clean_hold", {24'd0, Data_out}, 32'hA5);

      send(12'hA8C);
      chk_out("d2flip", 8'hA5, 4'b0011, 1'b1, 1'b0);
      chk("d2flip_cnt", {28'd0, corr_cnt}, 32'd1);
      tick();
      chk("d2flip_pulse", {31'd0, err_corr}, 32'd0);

      send(12'hEAC);
      chk_out("d6flip", 8'hA5, 4'b0111, 1'b1, 1'b0);
      chk("d6flip_cnt", {28'd0, corr_cnt}, 32'd2);

      send(12'hAAD);
      chk_out("c1flip", 8'hA5, 4'b0001, 1'b0, 1'b1);
      chk("c1flip_cnt", {28'd0, uncorr_cnt}, 32'd1);

      send(12'hAA8);
      chk_out("d0flip", 8'hA4, 4'b0001, 1'b0, 1'b1);

      send(12'h28C);
      chk_out("dbl", 8'h21, 4'b1011, 1'b0, 1'b1);
      chk("dbl_cnt", {28'd0, uncorr_cnt}, 32'd3);

      // qvld held through an EN-low cycle
      send(12'hAAC);
      chk("hold_qvld0", {31'd0, qvld}, 32'd1);
      EN = 1'b0;
      tick();
      chk("hold_qvld1", {31'd0, qvld}, 32'd1);
      EN = 1'b1;
      tick();
      chk("hold_qvld2", {31'd0, qvld}, 32'd0);

      // Four words with a 2-cycle stall after the second
      Data_in  = 12'h000;
      Data_vld = 1'b1;
      tick();
      Data_in = 12'hAA8;
      tick();
      Data_vld = 1'b0;
      EN       = 1'b0;
      tick();
      chk("stall_q3", {31'd0, qvld}, 32'd0);
      tick();
      chk("stall_q4", {31'd0, qvld}, 32'd0);
      EN       = 1'b1;
      Data_in  = 12'h28C;
      Data_vld = 1'b1;
      tick();
      chk_out("strm_w1", 8'h00, 4'b0000, 1'b0, 1'b0);
      Data_in = 12'hAAC;
      tick();
      chk_out("strm_w2", 8'hA4, 4'b0001, 1'b0, 1'b1);
      Data_vld = 1'b0;
      tick();
      chk_out("strm_w3", 8'h21, 4'b1011, 1'b0, 1'b1);
      tick();
      chk_out("strm_w4", 8'hA5, 4'b0000, 1'b0, 1'b0);
      tick();
      chk("strm_end", {31'd0, qvld}, 32'd0);
      chk("strm_ucnt", {28'd0, uncorr_cnt}, 32'd5);

      EN      = 1'b0;
      cnt_clr = 1'b1;
      tick();
      chk("clr_en0_c", {28'd0, corr_cnt}, 32'd2);
      chk("clr_en0_u", {28'd0, uncorr_cnt}, 32'd5);
      EN = 1'b1;
      tick();
      cnt_clr = 1'b0;
      chk("clr_c", {28'd0, corr_cnt}, 32'd0);
      chk("clr_u", {28'd0, uncorr_cnt}, 32'd0);

      Data_in  = 12'hA8C;
      Data_vld = 1'b1;
      for (int i = 0; i < 15; i++) tick();
      Data_vld = 1'b0;
      tick();
      tick();
      chk("sat_full", {28'd0, corr_cnt}, 32'hF);
      send(12'hA8C);
      chk("sat_flag", {31'd0, err_corr}, 32'd1);
      chk("sat_hold", {28'd0, corr_cnt}, 32'hF);

      // Clear lands on the same edge as a correctable result
      Data_in  = 12'hA8C;
      Data_vld = 1'b1;
      tick();
      Data_vld = 1'b0;
      tick();
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      chk("clrpri_flag", {31'd0, err_corr}, 32'd1);
      chk("clrpri_cnt", {28'd0, corr_cnt}, 32'd0);

      // Reset one cycle after a word is accepted
      Data_in  = 12'hA8C;
      Data_vld = 1'b1;
      tick();
      Data_vld = 1'b0;
      rst      = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("mrst_noq", {31'd0, qvld}, 32'd0);
         tick();
      end
      chk("mrst_data", {24'd0, Data_out}, 32'd0);
      chk("mrst_syn", {28'd0, syndrome}, 32'd0);
      chk("mrst_flags", {30'd0, err_corr, err_uncorr}, 32'd0);
      chk("mrst_cnts", {24'd0, corr_cnt, uncorr_cnt}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
